// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, PC constants
// and the RV32 major opcodes that decode also uses.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between the memory
// response path and decode; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) store[wr_ptr] <= push_data;
    end

    // Head reads as zero when empty so decode never sees stale contents.
    assign head_data = (count_q == '0) ? '0 : store[rd_ptr];
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests and
// buffers in-order responses for decode. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        fetch_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] out_next;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [63:0]   fifo_head;
    logic          req_fire;
    logic          redir_accept;
    logic          push;
    logic          pop;
    logic [31:0]   redir_target;
    logic          redir_misaligned;
    logic          fault_pend;

    assign redir_target = {redir_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_misaligned = |redir_pc[1:0];

    // Remembers that the latest redirect was misaligned so DRAIN exits into FAULT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)               fault_pend <= 1'b0;
        else if (redir_accept) fault_pend <= redir_misaligned;
    end

    assign fetch_fault = (state == FAULT);
`else
    logic unused_low_bits;
    assign unused_low_bits  = ^redir_pc[1:0];
    assign redir_misaligned = 1'b0;
    assign fault_pend       = 1'b0;
    assign fetch_fault      = 1'b0;
`endif

    assign mem_req_valid = (state == RUN) &&
                           (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign redir_accept  = redir_valid && (state != IDLE);
    assign inst_valid    = !fifo_empty && !redir_valid;
    assign pop           = inst_valid && inst_ready;
    assign push          = mem_rsp_valid && !redir_accept && (state == RUN) &&
                           (!fifo_full || pop);
    assign inst_pc       = fifo_head[63:32];
    assign inst_data     = fifo_head[31:0];

    always_comb begin
        out_next = outstanding;
        if (req_fire && !mem_rsp_valid)      out_next = outstanding + ONE;
        else if (!req_fire && mem_rsp_valid) out_next = outstanding - ONE;
    end

    // On a redirect every request still in flight, including one handshaking now,
    // becomes stale; a response arriving in the same cycle is already discarded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_next;
            if (req_fire) fetch_pc <= next_pc(fetch_pc);
            if (push)     rsp_pc   <= next_pc(rsp_pc);
            if (redir_accept) begin
                fetch_pc <= redir_target;
                rsp_pc   <= redir_target;
                drop     <= out_next;
                if (out_next != '0)    state <= DRAIN;
                else if (redir_misaligned) state <= FAULT;
                else                   state <= RUN;
            end else begin
                case (state)
                    IDLE: state <= RUN;
                    DRAIN: begin
                        if (mem_rsp_valid) begin
                            drop <= drop - ONE;
                            if (drop == ONE) state <= fault_pend ? FAULT : RUN;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(64)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .flush    (redir_accept),
        .push     (push),
        .pop      (pop),
        .push_data({rsp_pc, mem_rsp_data}),
        .head_data(fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: in-order memory model with random latency
// plus a queue-based model of in-flight requests and the decode buffer.
module tb_inst_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        fetch_fault;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .fetch_fault  (fetch_fault)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [31:0] pc; logic stale; } flight_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } inst_t;
    typedef struct { logic [31:0] data; int due; } mem_t;

    flight_t     inflight[$];
    inst_t       fifo_m[$];
    mem_t        memq[$];
    logic [31:0] m_fetch_pc;
    logic        m_started;
    logic        m_fault;

    int errors = 0;
    int checks = 0;
    int cyc, last_due, lat_min, lat_max, p_ready, p_iready, p_redir;
    logic        redir_force;
    logic [31:0] redir_force_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int stale_count();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].stale) n++;
        return n;
    endfunction

    function automatic logic exp_req_valid();
        return m_started && !m_fault && (stale_count() == 0) &&
               (inflight.size() + fifo_m.size() < DEPTH);
    endfunction

    function automatic logic exp_inst_valid();
        return (fifo_m.size() > 0) && !redir_valid;
    endfunction

    task automatic applyStimulus();
        mem_req_ready = ($urandom_range(99) < p_ready);
        inst_ready    = ($urandom_range(99) < p_iready);
        if (redir_force) begin
            redir_valid = 1'b1;
            redir_pc    = redir_force_pc;
        end else if ($urandom_range(999) < p_redir) begin
            redir_valid = 1'b1;
            redir_pc    = $urandom;
            if ($urandom_range(3) == 0) redir_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        end else begin
            redir_valid = 1'b0;
            redir_pc    = $urandom;
        end
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memq[0].data;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        #1;
    endtask

    task automatic checkOutput();
        check("mem_req_valid", mem_req_valid, exp_req_valid());
        if (exp_req_valid()) check("mem_req_addr", mem_req_addr, m_fetch_pc);
        check("inst_valid", inst_valid, exp_inst_valid());
        if (exp_inst_valid()) begin
            check("inst_pc", inst_pc, fifo_m[0].pc);
            check("inst_data", inst_data, fifo_m[0].data);
        end
        check("fetch_fault", fetch_fault, m_started && m_fault && (stale_count() == 0));
    endtask

    // Memory follows what the DUT actually requests; the model follows its own prediction.
    task automatic advance();
        flight_t f;
        logic req_m, pop_m, redir_m;
        int due;
        if (mem_req_valid && mem_req_ready) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{data: $urandom, due: due});
        end
        if (mem_rsp_valid && memq.size() > 0) void'(memq.pop_front());

        req_m   = exp_req_valid() && mem_req_ready;
        pop_m   = exp_inst_valid() && inst_ready;
        redir_m = redir_valid && m_started;
        if (!m_started) begin
            m_started = 1'b1;
        end else begin
            if (pop_m) void'(fifo_m.pop_front());
            if (mem_rsp_valid && inflight.size() > 0) begin
                f = inflight.pop_front();
                if (!f.stale && !redir_m) fifo_m.push_back('{pc: f.pc, data: mem_rsp_data});
            end
            if (req_m) begin
                inflight.push_back('{pc: m_fetch_pc, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redir_m) begin
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                fifo_m.delete();
                m_fetch_pc = {redir_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
                m_fault = (redir_pc[1:0] != 2'b00);
`else
                m_fault = 1'b0;
`endif
            end
        end
        @(negedge CLK);
        cyc++;
    endtask

    task automatic doReset();
        RST = 1'b1;
        mem_req_ready = 1'b0; inst_ready = 1'b0; redir_valid = 1'b0;
        redir_pc = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redir_force = 1'b0;
        #1;
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_addr", mem_req_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_fetch_fault", fetch_fault, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        inflight.delete(); fifo_m.delete(); memq.delete();
        m_fetch_pc = RESET_PC; m_started = 1'b0; m_fault = 1'b0;
        cyc = 0; last_due = -1;
    endtask

    initial begin
        int reqs, wrapped;
        logic [31:0] exp_next, first_pc, prev_hs;
        logic got_first;
        @(negedge CLK);

        // Steady fetch from reset with a one-cycle memory.
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(); checkOutput();
            if (cyc == 0) check("idle_no_req", mem_req_valid, 1'b0);
            if (cyc == 1) begin
                check("first_req_valid", mem_req_valid, 1'b1);
                check("first_req_addr", mem_req_addr, 32'h0);
            end
            if (cyc == 2) check("second_req_addr", mem_req_addr, 32'h4);
            if (cyc == 3) begin
                check("first_inst_valid", inst_valid, 1'b1);
                check("first_inst_pc", inst_pc, 32'h0);
            end
            advance();
        end

        // Decode stalled: credits stop requests, nothing lost on release.
        p_iready = 0;
        doReset();
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(); checkOutput();
            if (mem_req_valid && mem_req_ready) reqs++;
            if (cyc == 5) check("stall_req_valid", mem_req_valid, 1'b0);
            advance();
        end
        check("stall_req_count", reqs, 2);
        p_iready = 100; exp_next = 32'h0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(); checkOutput();
            if (inst_valid && inst_ready) begin
                check("release_order", inst_pc, exp_next);
                exp_next = exp_next + 32'd4;
            end
            advance();
        end

        // Redirect with two requests outstanding, three-cycle memory.
        lat_min = 3; lat_max = 3;
        doReset();
        got_first = 1'b0; first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            redir_force = (cyc == 3); redir_force_pc = 32'h100;
            applyStimulus(); checkOutput();
            if (cyc == 4) check("drain_no_req", mem_req_valid, 1'b0);
            if (cyc == 6) begin
                check("redir_req_valid", mem_req_valid, 1'b1);
                check("redir_req_addr", mem_req_addr, 32'h100);
            end
            if (cyc > 3 && inst_valid && inst_ready && !got_first) begin
                first_pc = inst_pc; got_first = 1'b1;
            end
            advance();
        end
        check("redir_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response and a request handshake.
        lat_min = 1; lat_max = 1;
        doReset();
        got_first = 1'b0; first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 12; i++) begin
            redir_force = (cyc == 2); redir_force_pc = 32'h200;
            applyStimulus(); checkOutput();
            if (cyc == 3) check("coinc_drain", mem_req_valid, 1'b0);
            if (cyc == 4) check("coinc_req_addr", mem_req_addr, 32'h200);
            if (cyc > 2 && inst_valid && inst_ready && !got_first) begin
                first_pc = inst_pc; got_first = 1'b1;
            end
            advance();
        end
        check("coinc_first_pc", first_pc, 32'h200);

        // PC wrap from the top of the address space.
        doReset();
        wrapped = 0; prev_hs = 32'h1;
        for (int i = 0; i < 14; i++) begin
            redir_force = (cyc == 1); redir_force_pc = 32'hFFFF_FFF8;
            applyStimulus(); checkOutput();
            if (mem_req_valid && mem_req_ready) begin
                if (prev_hs == 32'hFFFF_FFFC) begin
                    check("wrap_addr", mem_req_addr, 32'h0);
                    wrapped = 1;
                end
                prev_hs = mem_req_addr;
            end
            advance();
        end
        check("wrap_reached", wrapped, 1);

        // Misaligned redirect handling.
        doReset();
        for (int i = 0; i < 16; i++) begin
            redir_force = (cyc == 4) || (cyc == 10);
            redir_force_pc = (cyc == 4) ? 32'h102 : 32'h104;
            applyStimulus(); checkOutput();
`ifdef FETCH_ALIGN_CHECK_EN
            if (cyc == 7) begin
                check("fault_flag", fetch_fault, 1'b1);
                check("fault_no_req", mem_req_valid, 1'b0);
                check("fault_no_inst", inst_valid, 1'b0);
            end
            if (cyc == 11) begin
                check("fault_cleared", fetch_fault, 1'b0);
                check("resume_req_addr", mem_req_addr, 32'h104);
            end
`else
            if (cyc == 6) begin
                check("forced_align_addr", mem_req_addr, 32'h100);
                check("no_fault", fetch_fault, 1'b0);
            end
`endif
            advance();
        end

        // Randomized traffic with a mid-run reset.
        lat_min = 1; lat_max = 4; p_ready = 70; p_iready = 70; p_redir = 40;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            applyStimulus(); checkOutput(); advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
